// File: rtl/adc_spi_config.sv
// Write-only 3-wire SPI master for ADC register programming.
// One 24-bit frame per valid/ready handshake, MSB first.
module adc_spi_config #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        busy,
  output logic        done,
  output logic        adc_csbn,
  output logic        adc_sclk,
  output logic        adc_sdio
);

  localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAXC = (M1 > CS_HOLD) ? M1 : CS_HOLD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DIV_LD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SET_LD  = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   sh_q, sh_d;
  logic          csbn_q, csbn_d;
  logic          sclk_q, sclk_d;
  logic          sdio_q, sdio_d;
  logic          done_q, done_d;
  logic [23:0]   frame;

  // Write command, one data byte, then address and value.
  assign frame     = {3'b000, req_addr, req_data};
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign adc_csbn  = csbn_q;
  assign adc_sclk  = sclk_q;
  assign adc_sdio  = sdio_q;

  // State, counters and all serial outputs are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      csbn_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      csbn_q  <= csbn_d;
      sclk_q  <= sclk_d;
      sdio_q  <= sdio_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output decode; phase counter reloads per phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    csbn_d  = csbn_q;
    sclk_d  = sclk_q;
    sdio_d  = sdio_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          cnt_d   = SET_LD;
          sh_d    = frame;
          bit_d   = 5'd23;
          csbn_d  = 1'b0;
          sclk_d  = 1'b0;
          sdio_d  = frame[23];
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = SHIFT;
          cnt_d   = DIV_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          cnt_d  = DIV_LD;
        end else begin
          // Falling edge: present the next bit.
          sclk_d = 1'b0;
          sdio_d = sh_q[22];
          sh_d   = {sh_q[22:0], 1'b0};
          if (bit_q == 5'd0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            bit_d = bit_q - 5'd1;
            cnt_d = DIV_LD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = DIV_LD;
          csbn_d  = 1'b1;
          sdio_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_spi_config.sv
// Bench for adc_spi_config: default build and a CLK_DIV=1 build.
// Closed-form timing model per cycle plus an SPI slave capture.
module tb_adc_spi_config;

  logic        clk;
  logic        reset_n = 1'b0;
  logic [1:0]  valid;
  logic [12:0] addr [2];
  logic [7:0]  data [2];
  logic [1:0]  ready, busy, done, csbn, sclk, sdio;

  int ps[2] = '{2, 1};
  int pd[2] = '{4, 1};
  int ph[2] = '{2, 1};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit          active[2];
  int          t0[2];
  logic [23:0] mframe[2];
  int          lowcnt[2];
  int          last_low[2];
  int          rise_cyc[2];
  int          gap[2];
  int          ndone[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adc_spi_config dut0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(valid[0]),
    .req_ready(ready[0]),
    .req_addr (addr[0]),
    .req_data (data[0]),
    .busy     (busy[0]),
    .done     (done[0]),
    .adc_csbn (csbn[0]),
    .adc_sclk (sclk[0]),
    .adc_sdio (sdio[0])
  );

  adc_spi_config #(
    .CLK_DIV (1),
    .CS_SETUP(1),
    .CS_HOLD (1)
  ) dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(valid[1]),
    .req_ready(ready[1]),
    .req_addr (addr[1]),
    .req_data (data[1]),
    .busy     (busy[1]),
    .done     (done[1]),
    .adc_csbn (csbn[1]),
    .adc_sclk (sclk[1]),
    .adc_sdio (sdio[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout %s", nm);
  endtask

  // Expected {sdio_care, csbn, sclk, sdio, done, busy, ready}
  // k cycles after the accepting edge (k=0 means idle).
  function automatic logic [6:0] expv(int k, int s, int dv, int h,
                                      logic [23:0] f);
    int l, m, j;
    logic [6:0] e;
    l = s + 48 * dv + h;
    e = 7'b1100001;
    if (k == 0) e = 7'b1100001;
    else if (k <= s) e = {3'b100, f[23], 3'b010};
    else if (k <= s + 48 * dv) begin
      m = k - s - 1;
      j = m / (2 * dv);
      e = {2'b10, (m % (2 * dv)) >= dv, f[23 - j], 3'b010};
    end
    else if (k <= l) e = 7'b0000010;
    else if (k == l + 1) e = 7'b1100110;
    else e = 7'b1100010;
    return e;
  endfunction

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int l, k;
      logic [6:0] e;
      logic [5:0] m, a;
      l = ps[i] + 48 * pd[i] + ph[i];
      if (!reset_n) active[i] = 1'b0;
      if (active[i] && (cyc - t0[i]) > l + pd[i]) active[i] = 1'b0;
      k = active[i] ? cyc - t0[i] : 0;
      e = expv(k, ps[i], pd[i], ph[i], mframe[i]);
      m = e[6] ? 6'h3F : 6'h37;
      a = {csbn[i], sclk[i], sdio[i], done[i], busy[i], ready[i]};
      chk($sformatf("outs%0d k=%0d", i, k), a & m, e[5:0] & m);
      if (!reset_n) lowcnt[i] = 0;
      else if (!csbn[i]) lowcnt[i]++;
      else if (lowcnt[i] != 0) begin
        last_low[i] = lowcnt[i];
        lowcnt[i]   = 0;
        rise_cyc[i] = cyc;
      end
      if (done[i] === 1'b1) ndone[i]++;
      if (reset_n && !active[i] && valid[i]) begin
        active[i] = 1'b1;
        t0[i]     = cyc;
        mframe[i] = {3'b000, addr[i], data[i]};
        gap[i]    = cyc - rise_cyc[i];
      end
    end
  end

  // SPI slave: samples sdio on each sclk rising edge.
  for (genvar g = 0; g < 2; g++) begin : cp
    logic [23:0] cap;
    logic [23:0] last;
    logic [23:0] prev;
    int nedge = 0;
    int nfr = 0;

    always @(negedge csbn[g]) begin
      cap   <= '0;
      nedge <= 0;
    end

    always @(posedge sclk[g]) begin
      chk($sformatf("sclk_cs%0d", g), csbn[g], 1'b0);
      cap   <= {cap[22:0], sdio[g]};
      nedge <= nedge + 1;
    end

    always @(posedge csbn[g]) begin
      if (reset_n === 1'b1) begin
        chk($sformatf("frame%0d", g), cap, mframe[g]);
        chk($sformatf("edges%0d", g), nedge, 24);
        prev <= last;
        last <= cap;
        nfr  <= nfr + 1;
      end
    end
  end

  task automatic send(input int i, input logic [12:0] a,
                      input logic [7:0] d, input bit hold);
    int n;
    @(posedge clk);
    #1;
    valid[i] = 1'b1;
    addr[i]  = a;
    data[i]  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[i] && n < 2000);
    if (!ready[i]) tmo("send");
    @(posedge clk);
    #1;
    if (!hold) valid[i] = 1'b0;
    addr[i] = 13'($urandom);
    data[i] = 8'($urandom);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[i] && n < 3000);
    if (!ready[i]) tmo("idle");
  endtask

  task automatic rst_chk(input string nm, input int i);
    chk(nm, {csbn[i], sclk[i], sdio[i], busy[i], done[i], ready[i]},
        6'b100001);
  endtask

  initial begin
    int n0, f0, n;
    logic [12:0] ra;
    logic [7:0]  rd;
    valid   = '0;
    addr[0] = '0;
    addr[1] = '0;
    data[0] = '0;
    data[1] = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Reset applied between edges, then a quiet period.
    #3 reset_n = 1'b0;
    #1;
    rst_chk("rst_a0", 0);
    rst_chk("rst_a1", 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (50) @(posedge clk);

    // Single write with the default build.
    n0 = ndone[0];
    send(0, 13'h014, 8'h01, 1'b0);
    wait_idle(0);
    chk("single_frame", cp[0].last, 24'h001401);
    chk("single_low", last_low[0], 196);
    chk("single_done", ndone[0] - n0, 1);

    // Back-to-back with req_valid held.
    n0 = ndone[0];
    send(0, 13'h008, 8'h05, 1'b1);
    send(0, 13'h0FF, 8'h01, 1'b0);
    wait_idle(0);
    chk("b2b_gap", gap[0], 4);
    chk("b2b_first", cp[0].prev, 24'h000805);
    chk("b2b_second", cp[0].last, 24'h00FF01);
    chk("b2b_done", ndone[0] - n0, 2);

    // Requests while busy are ignored.
    f0 = cp[0].nfr;
    ra = 13'($urandom);
    rd = 8'($urandom);
    send(0, ra, rd, 1'b0);
    n = 0;
    while (cp[0].nedge < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (cp[0].nedge < 3) tmo("busy_edges");
    repeat (100) begin
      @(posedge clk);
      #1;
      valid[0] = 1'($urandom);
      addr[0]  = 13'($urandom);
      data[0]  = 8'($urandom);
    end
    valid[0] = 1'b0;
    wait_idle(0);
    chk("busy_frame", cp[0].last, {3'b000, ra, rd});
    chk("busy_nfr", cp[0].nfr - f0, 1);

    // Reset after 10 rising edges abandons the frame.
    f0 = cp[0].nfr;
    send(0, 13'($urandom), 8'($urandom), 1'b0);
    n = 0;
    while (cp[0].nedge < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (cp[0].nedge < 10) tmo("mid_edges");
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    rst_chk("rst_mid", 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    send(0, 13'h1FFF, 8'hFF, 1'b0);
    wait_idle(0);
    chk("post_rst_frame", cp[0].last, 24'h1FFFFF);
    chk("post_rst_nfr", cp[0].nfr - f0, 1);

    // Randomised traffic with random gaps.
    repeat (12) begin
      send(0, 13'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    #1 valid[0] = 1'b0;
    wait_idle(0);

    // Fastest build: CLK_DIV=1, CS_SETUP=1, CS_HOLD=1.
    n0 = ndone[1];
    send(1, 13'h0AB, 8'h5A, 1'b0);
    wait_idle(1);
    chk("fast_frame", cp[1].last, 24'h00AB5A);
    chk("fast_low", last_low[1], 50);
    chk("fast_done", ndone[1] - n0, 1);
    repeat (5) begin
      send(1, 13'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    #1 valid[1] = 1'b0;
    wait_idle(1);
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
